decimal_display_sequencer: RTL

Multi-cycle signed binary-to-decimal converter for the seven-segment display path. It accepts a 32-bit two's-complement value over a valid/ready handshake. It converts the magnitude with a sequenced double-dabble (shift-add-3) engine, one bit per clock, then presents registered BCD digits, a sign flag and an overflow flag. This replaces wide combinational divide/modulo logic with a small FSM and keeps outputs stable between updates. External seven_segment / seven_segment_negative decoders are driven from its outputs.

---
 rtl/decimal_display_sequencer_pkg.sv | 23 ++
 rtl/decimal_display_sequencer_if.sv | 25 ++
 rtl/decimal_display_sequencer_bcd_add3.sv | 9 +
 rtl/decimal_display_sequencer.sv | 101 ++++++++++
 4 files changed

// File: rtl/decimal_display_sequencer_pkg.sv
// Shared types and constants for the signed binary-to-BCD display sequencer.
// Holds the FSM encoding, accumulator sizing and the two's-complement magnitude helper.
package decimal_display_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int BCD_DIGITS  = 10;
    localparam int SHIFT_COUNT = 32;
    localparam int CNT_W       = $clog2(SHIFT_COUNT);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SHIFT_COUNT - 1);

    // 0x80000000 maps to 2147483648, which still fits in 32 unsigned bits
    function automatic logic [31:0] magnitude(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/decimal_display_sequencer_if.sv
// Request/result bundle between a value producer and the decimal display sequencer.
// master drives the request and observes results; slave is the converter.
interface decimal_display_sequencer_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int DISP_DIGITS = 5
);
    logic [DATA_WIDTH-1:0]    in_val;
    logic                     in_valid;
    logic                     in_ready;
    logic [4*DISP_DIGITS-1:0] bcd_digits;
    logic                     is_negative;
    logic                     overflow;
    logic                     out_valid;
    logic                     busy;

    modport master (
        output in_val, in_valid,
        input  in_ready, bcd_digits, is_negative, overflow, out_valid, busy
    );

    modport slave (
        input  in_val, in_valid,
        output in_ready, bcd_digits, is_negative, overflow, out_valid, busy
    );
endinterface

// File: rtl/decimal_display_sequencer_bcd_add3.sv
// Purpose: double-dabble digit correction, adds 3 to a BCD digit of 5 or more.
// Latency: combinational.
// Backpressure: none.
module decimal_display_sequencer_bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);
    assign dout = (din >= 4'd5) ? (din + 4'd3) : din;
endmodule

// File: rtl/decimal_display_sequencer.sv
// Purpose: signed 32-bit to registered BCD digits with sign and overflow flags.
// Latency: out_valid pulses 34 clocks after the accept edge; outputs hold between updates.
// Backpressure: in_ready only in IDLE, requests while busy are ignored (no queueing).
module decimal_display_sequencer
    import decimal_display_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int DISP_DIGITS = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    decimal_display_sequencer_if.slave   dd
);

    state_t                   state_q, state_d;
    logic [DATA_WIDTH-1:0]    in_q;
    logic [DATA_WIDTH-1:0]    shreg;
    logic [4*BCD_DIGITS-1:0]  acc;
    logic [4*BCD_DIGITS-1:0]  acc_adj;
    logic                     sign_pend;
    logic [CNT_W-1:0]         cnt;
    logic                     ovf_c;

    logic [4*DISP_DIGITS-1:0] bcd_q;
    logic                     neg_q;
    logic                     ovf_q;
    logic                     vld_q;

    for (genvar d = 0; d < BCD_DIGITS; d++) begin : g_add3
        decimal_display_sequencer_bcd_add3 u_add3 (
            .din  (acc[4*d +: 4]),
            .dout (acc_adj[4*d +: 4])
        );
    end

    // Digits beyond the displayed window only feed the overflow flag
    if (DISP_DIGITS < BCD_DIGITS) begin : g_ovf
        assign ovf_c = |acc[4*BCD_DIGITS-1:4*DISP_DIGITS];
    end else begin : g_no_ovf
        assign ovf_c = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (dd.in_valid && dd.in_ready) state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_SHIFT;
            ST_SHIFT: if (cnt == LAST_BIT) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            in_q      <= '0;
            shreg     <= '0;
            acc       <= '0;
            sign_pend <= 1'b0;
            cnt       <= '0;
            bcd_q     <= '0;
            neg_q     <= 1'b0;
            ovf_q     <= 1'b0;
            vld_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            vld_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (dd.in_valid) in_q <= dd.in_val;
                end
                ST_LOAD: begin
                    shreg     <= magnitude(in_q);
                    acc       <= '0;
                    sign_pend <= in_q[DATA_WIDTH-1];
                    cnt       <= '0;
                end
                ST_SHIFT: begin
                    {acc, shreg} <= {acc_adj, shreg} << 1;
                    cnt          <= cnt + 1'b1;
                end
                ST_DONE: begin
                    bcd_q <= acc[4*DISP_DIGITS-1:0];
                    neg_q <= sign_pend;
                    ovf_q <= ovf_c;
                    vld_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign dd.in_ready    = (state_q == ST_IDLE) && !rst;
    assign dd.busy        = (state_q != ST_IDLE);
    assign dd.bcd_digits  = bcd_q;
    assign dd.is_negative = neg_q;
    assign dd.overflow    = ovf_q;
    assign dd.out_valid   = vld_q;

endmodule
